// File: rtl/lcd_text_engine.sv
// lcd_text_engine: HD44780-compatible character-LCD controller (8-bit bus).
// Buffers characters in a FIFO and runs the power-on init sequence. It
// tracks the cursor and auto-wraps across a ROWS x COLS display.
// Optional feature macro: LCD_CTRL_CHARS_EN. When it is defined, 0x0A is
// treated as newline and 0x0C as form-feed (clear). Otherwise every byte is
// written to the display as data.
module lcd_text_engine #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int ROWS       = 2,
    parameter int COLS       = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int T_PWR_CYC  = 750_000,
    parameter int T_EN_CYC   = 25,
    parameter int T_CMD_CYC  = 2_000,
    parameter int T_CLR_CYC  = 82_000
) (
    input  logic                                      clk,
    input  logic                                      rstb,
    input  logic [7:0]                                char_in,
    input  logic                                      char_valid,
    output logic                                      char_ready,
    output logic                                      busy,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] cursor_row,
    output logic [$clog2(COLS)-1:0]                   cursor_col,
    output logic [7:0]                                lcd_data,
    output logic                                      lcd_rs,
    output logic                                      lcd_rw,
    output logic                                      lcd_en
);

    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW   = $clog2(COLS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(T_PWR_CYC + T_CLR_CYC + T_CMD_CYC + T_EN_CYC + 2);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(T_PWR_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(T_EN_CYC);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(T_CMD_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(T_CLR_CYC - 1);
    localparam logic [AW:0]      FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [RW-1:0]    ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CLW-1:0]   COL_LAST  = CLW'(COLS - 1);
    localparam logic [2:0]       INIT_CMDS = 3'd4;

    // Reject illegal configurations at elaboration time.
    generate
        if (ROWS != 1 && ROWS != 2 && ROWS != 4) begin : g_bad_rows
            $error("lcd_text_engine: ROWS must be 1, 2 or 4");
        end
        if (COLS < 8 || COLS > 40) begin : g_bad_cols
            $error("lcd_text_engine: COLS must be 8..40");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("lcd_text_engine: FIFO_DEPTH must be a power of 2, >= 2");
        end
        if (CLK_HZ <= 0) begin : g_bad_clk
            $error("lcd_text_engine: CLK_HZ must be positive");
        end
    endgenerate

    // PWR_WAIT -> INIT -> IDLE <-> XFER -> WAIT.
    // INIT and XFER each cover the setup cycle and the enable pulse.
    // INIT is used for init commands and XFER for everything else.
    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, XFER, WAIT} state_t;
    // What the in-flight transaction does to the cursor when its wait ends.
    typedef enum logic [1:0] {TX_CMD, TX_DATA, TX_NEWLINE, TX_CLEAR} tx_kind_t;

    // Init command for step idx; the function set depends on the row count.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return (ROWS == 1) ? 8'h30 : 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Set-DDRAM command for column 0 of row r.
    function automatic logic [7:0] set_ddram(input logic [RW-1:0] r);
        case (int'(r))
            0:       return 8'h80;
            1:       return 8'hC0;
            2:       return 8'h80 + 8'(COLS);
            default: return 8'hC0 + 8'(COLS);
        endcase
    endfunction

    // ---------------- character FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_count;
    logic          fifo_empty, push, pop;
    logic [7:0]    fifo_head;

    assign char_ready = (fifo_count != FIFO_FULL);
    assign fifo_empty = (fifo_count == '0);
    assign push       = char_valid && char_ready;
    assign fifo_head  = fifo_mem[rd_ptr];

    // Pointer and occupancy tracking; reset discards any buffered text.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage write.
    // NOTE: the storage array has no reset; the pointers alone define
    // which entries are valid, so it can map to plain RAM.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= char_in;
    end

    // ---------------- sequencer ----------------
    state_t           state, state_n;
    tx_kind_t         kind, kind_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       init_idx, init_idx_n;
    logic             long_wait, long_wait_n;
    logic             held_valid, held_valid_n;
    logic [7:0]       held_char, held_char_n;
    logic [RW-1:0]    row, row_n, row_inc;
    logic [CLW-1:0]   col, col_n;
    logic             pending, pending_n;
    logic [7:0]       data_n;
    logic             rs_n, en_n;
    logic             wait_done, is_newline, is_clear;

    assign row_inc   = (row == ROW_LAST) ? '0 : row + 1'b1;
    assign wait_done = (cnt == (long_wait ? CLR_LAST : CMD_LAST));

`ifdef LCD_CTRL_CHARS_EN
    assign is_newline = (fifo_head == 8'h0A);
    assign is_clear   = (fifo_head == 8'h0C);
`else
    assign is_newline = 1'b0;
    assign is_clear   = 1'b0;
`endif

    // Next-state, transaction loading and cursor bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default first so that no path through
        // the case statement can infer a latch.
        state_n      = state;
        kind_n       = kind;
        cnt_n        = cnt;
        init_idx_n   = init_idx;
        long_wait_n  = long_wait;
        held_valid_n = held_valid;
        held_char_n  = held_char;
        row_n        = row;
        col_n        = col;
        pending_n    = pending;
        data_n       = lcd_data;
        rs_n         = lcd_rs;
        en_n         = 1'b0;
        pop          = 1'b0;

        case (state)
            PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    state_n     = INIT;
                    cnt_n       = '0;
                    data_n      = init_cmd(3'd0);
                    rs_n        = 1'b0;
                    kind_n      = TX_CMD;
                    long_wait_n = 1'b0;
                    init_idx_n  = 3'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            INIT, XFER: begin
                // cnt 0 is the setup cycle; cnt 1..T_EN_CYC drive the strobe.
                if (cnt == EN_LAST) begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                    en_n  = 1'b1;
                end
            end

            WAIT: begin
                if (wait_done) begin
                    cnt_n = '0;
                    case (kind)
                        TX_DATA: begin
                            if (col == COL_LAST) begin
                                col_n     = '0;
                                row_n     = row_inc;
                                pending_n = 1'b1;
                            end else begin
                                col_n = col + 1'b1;
                            end
                        end
                        TX_NEWLINE: begin
                            row_n = row_inc;
                            col_n = '0;
                        end
                        TX_CLEAR: begin
                            row_n = '0;
                            col_n = '0;
                        end
                        default: ;
                    endcase
                    // Chain the next transaction with no gap when one is due.
                    if (init_idx != INIT_CMDS) begin
                        state_n     = INIT;
                        data_n      = init_cmd(init_idx);
                        rs_n        = 1'b0;
                        kind_n      = TX_CMD;
                        long_wait_n = (init_idx == 3'd2);
                        init_idx_n  = init_idx + 1'b1;
                    end else if (held_valid) begin
                        state_n      = XFER;
                        data_n       = held_char;
                        rs_n         = 1'b1;
                        kind_n       = TX_DATA;
                        long_wait_n  = 1'b0;
                        held_valid_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    state_n     = XFER;
                    cnt_n       = '0;
                    rs_n        = 1'b0;
                    kind_n      = TX_CMD;
                    long_wait_n = 1'b0;
                    if (is_newline) begin
                        data_n    = set_ddram(row_inc);
                        kind_n    = TX_NEWLINE;
                        pending_n = 1'b0;
                    end else if (is_clear) begin
                        data_n      = 8'h01;
                        kind_n      = TX_CLEAR;
                        long_wait_n = 1'b1;
                        pending_n   = 1'b0;
                    end else if (pending) begin
                        // Re-address the LCD after a wrap, then write the byte.
                        data_n       = set_ddram(row);
                        held_char_n  = fifo_head;
                        held_valid_n = 1'b1;
                        pending_n    = 1'b0;
                    end else begin
                        data_n = fifo_head;
                        rs_n   = 1'b1;
                        kind_n = TX_DATA;
                    end
                end
            end

            default: state_n = PWR_WAIT;
        endcase
    end

    // State and registered LCD pins; reset drops lcd_en immediately.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= PWR_WAIT;
            kind       <= TX_CMD;
            cnt        <= '0;
            init_idx   <= '0;
            long_wait  <= 1'b0;
            held_valid <= 1'b0;
            held_char  <= '0;
            row        <= '0;
            col        <= '0;
            pending    <= 1'b0;
            lcd_data   <= '0;
            lcd_rs     <= 1'b0;
            lcd_en     <= 1'b0;
        end else begin
            state      <= state_n;
            kind       <= kind_n;
            cnt        <= cnt_n;
            init_idx   <= init_idx_n;
            long_wait  <= long_wait_n;
            held_valid <= held_valid_n;
            held_char  <= held_char_n;
            row        <= row_n;
            col        <= col_n;
            pending    <= pending_n;
            lcd_data   <= data_n;
            lcd_rs     <= rs_n;
            lcd_en     <= en_n;
        end
    end

    assign busy       = (state != IDLE) || !fifo_empty;
    assign cursor_row = row;
    assign cursor_col = col;
    assign lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_text_engine.sv
// tb_lcd_text_engine: directed bench for lcd_text_engine on a 2x4 display.
// Timing uses T_PWR=20, T_EN=2, T_CMD=5 and T_CLR=10.
// Cycle k is the k-th clock period after rstb releases; cycle 0 is the
// period before the first rising edge. From this, the init command rises
// are at cycles 21/29/37/50 and the FSM reaches IDLE at cycle 57.
module tb_lcd_text_engine;

    logic       clk;
    logic       rstb;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       busy;
    logic [0:0] cursor_row;
    logic [1:0] cursor_col;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    lcd_text_engine #(
        .CLK_HZ    (50_000_000),
        .ROWS      (2),
        .COLS      (4),
        .FIFO_DEPTH(4),
        .T_PWR_CYC (20),
        .T_EN_CYC  (2),
        .T_CMD_CYC (5),
        .T_CLR_CYC (10)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .char_in   (char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .busy      (busy),
        .cursor_row(cursor_row),
        .cursor_col(cursor_col),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         cyc;
    } tx_t;

    tx_t  txq[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc;
    logic en_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter, restarted by every reset.
    always @(posedge clk or negedge rstb) begin
        if (!rstb) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Record each lcd_en rising edge with the bus contents and cycle number.
    always @(negedge clk) begin
        if (rstb && lcd_en && !en_prev) txq.push_back('{lcd_rs, lcd_data, cyc});
        en_prev <= lcd_en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tx_word(input int i);
        if (i < txq.size()) return {23'd0, txq[i].rs, txq[i].data};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int tx_cyc(input int i);
        if (i < txq.size()) return txq[i].cyc;
        return -1;
    endfunction

    task automatic check_tx(input string tag, input int i, input logic rs, input logic [7:0] d);
        check(tag, tx_word(i), {23'd0, rs, d});
    endtask

    task automatic check_init(input string tag);
        check({tag, "_cmd0"}, tx_word(0), 32'h038);
        check({tag, "_cmd1"}, tx_word(1), 32'h00C);
        check({tag, "_cmd2"}, tx_word(2), 32'h001);
        check({tag, "_cmd3"}, tx_word(3), 32'h006);
    endtask

    // Called at a falling edge; returns at a falling edge with rstb released.
    task automatic apply_reset();
        char_valid = 1'b0;
        char_in    = 8'h00;
        rstb       = 1'b0;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        txq.delete();
    endtask

    // Push one byte; acc is the cycle whose closing edge accepted it.
    task automatic push(input logic [7:0] b, output int acc);
        int n;
        n          = 0;
        char_in    = b;
        char_valid = 1'b1;
        while (!char_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        check("push_ready", char_ready, 1'b1);
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int at);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int at;
        int bad;

        rstb       = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;

        // ---- Reset release and init sequence ----
        apply_reset();
        check("rst_lcd_data", lcd_data, 8'h00);
        check("rst_lcd_rs", lcd_rs, 1'b0);
        check("rst_lcd_rw", lcd_rw, 1'b0);
        check("rst_lcd_en", lcd_en, 1'b0);
        check("rst_char_ready", char_ready, 1'b1);
        check("rst_busy", busy, 1'b1);
        check("rst_cursor_row", cursor_row, 1'b0);
        check("rst_cursor_col", cursor_col, 2'd0);
        bad = 0;
        for (int k = 0; k <= 20; k++) begin
            if (lcd_en !== 1'b0) bad++;
            @(negedge clk);
        end
        check("pwr_wait_en_low_cycles", bad, 0);
        check("first_en_rise_cyc21", lcd_en, 1'b1);
        wait_cyc(56);
        check("busy_before_idle", busy, 1'b1);
        @(negedge clk);
        check("busy_fall_cyc57", busy, 1'b0);
        check("init_tx_count", txq.size(), 4);
        check_init("init");
        check("init_rise0", tx_cyc(0), 21);
        check("init_rise1", tx_cyc(1), 29);
        check("init_rise2", tx_cyc(2), 37);
        check("init_clear_wait_rise3", tx_cyc(3), 50);

        // ---- "ABCDE": wrap to row 1 via 0xC0 ----
        for (int i = 0; i < 5; i++) push(8'h41 + 8'(i), acc);
        wait_idle("abcde_idle", at);
        for (int i = 0; i < 4; i++) check_tx("abcde_data", 4 + i, 1'b1, 8'h41 + 8'(i));
        check_tx("abcde_wrap_cmd", 8, 1'b0, 8'hC0);
        check_tx("abcde_data_e", 9, 1'b1, 8'h45);
        check("abcde_tx_count", txq.size(), 10);
        check("abcde_row", cursor_row, 1'b1);
        check("abcde_col", cursor_col, 2'd1);
        check("abcde_pop_gap", tx_cyc(5) - tx_cyc(4), 9);
        check("abcde_cmd_data_gap", tx_cyc(9) - tx_cyc(8), 8);

        // ---- 9 characters: wrap past the last row back to 0,0 ----
        apply_reset();
        wait_idle("full_init_idle", at);
        check("full_init_idle_cyc", at, 57);
        for (int i = 0; i < 9; i++) push(8'h61 + 8'(i), acc);
        wait_idle("full_idle", at);
        for (int i = 0; i < 4; i++) check_tx("full_row0", 4 + i, 1'b1, 8'h61 + 8'(i));
        check_tx("full_cmd_row1", 8, 1'b0, 8'hC0);
        for (int i = 0; i < 4; i++) check_tx("full_row1", 9 + i, 1'b1, 8'h65 + 8'(i));
        check_tx("full_cmd_row0", 13, 1'b0, 8'h80);
        check_tx("full_data_9th", 14, 1'b1, 8'h69);
        check("full_tx_count", txq.size(), 15);
        check("full_row", cursor_row, 1'b0);
        check("full_col", cursor_col, 2'd1);

        // ---- Control codes ----
        apply_reset();
        wait_idle("ctrl_init_idle", at);
`ifdef LCD_CTRL_CHARS_EN
        push(8'h41, acc);
        push(8'h0A, acc);
        push(8'h42, acc);
        wait_idle("nl_idle", at);
        check_tx("nl_data_a", 4, 1'b1, 8'h41);
        check_tx("nl_cmd", 5, 1'b0, 8'hC0);
        check_tx("nl_data_b", 6, 1'b1, 8'h42);
        check("nl_tx_count", txq.size(), 7);
        check("nl_row", cursor_row, 1'b1);
        check("nl_col", cursor_col, 2'd1);
        push(8'h0C, acc);
        wait_idle("ff_idle", at);
        check_tx("ff_cmd", 7, 1'b0, 8'h01);
        check("ff_clear_wait", at - tx_cyc(7), 12);
        check("ff_row", cursor_row, 1'b0);
        check("ff_col", cursor_col, 2'd0);
        push(8'h5A, acc);
        wait_idle("ff_after_idle", at);
        check_tx("ff_after_data", 8, 1'b1, 8'h5A);
        check("ff_after_tx_count", txq.size(), 9);
`else
        push(8'h41, acc);
        push(8'h0A, acc);
        push(8'h42, acc);
        push(8'h0C, acc);
        wait_idle("raw_idle", at);
        check_tx("raw_a", 4, 1'b1, 8'h41);
        check_tx("raw_0a", 5, 1'b1, 8'h0A);
        check_tx("raw_b", 6, 1'b1, 8'h42);
        check_tx("raw_0c", 7, 1'b1, 8'h0C);
        check("raw_tx_count", txq.size(), 8);
        check("raw_row", cursor_row, 1'b1);
        check("raw_col", cursor_col, 2'd0);
`endif

        // ---- Pushes during PWR_WAIT: back-pressure and ordering ----
        apply_reset();
        for (int i = 0; i < 4; i++) push(8'h31 + 8'(i), acc);
        check("pwr_full_ready_low", char_ready, 1'b0);
        check("pwr_full_busy", busy, 1'b1);
        push(8'h35, acc);
        check("pwr_5th_accept_cyc", acc, 58);
        push(8'h36, acc);
        check("pwr_6th_accept_cyc", acc, 67);
        wait_idle("pwr_idle", at);
        check_init("pwr");
        for (int i = 0; i < 4; i++) check_tx("pwr_row0", 4 + i, 1'b1, 8'h31 + 8'(i));
        check_tx("pwr_wrap_cmd", 8, 1'b0, 8'hC0);
        check_tx("pwr_data5", 9, 1'b1, 8'h35);
        check_tx("pwr_data6", 10, 1'b1, 8'h36);
        check("pwr_tx_count", txq.size(), 11);
        check("pwr_first_data_rise", tx_cyc(4), 59);

        // ---- Reset while lcd_en is high ----
        apply_reset();
        wait_idle("abort_init_idle", at);
        for (int i = 0; i < 4; i++) push(8'h71 + 8'(i), acc);
        bad = 0;
        while (!lcd_en && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        check("abort_en_seen", lcd_en, 1'b1);
        #2 rstb = 1'b0;
        #1;
        check("abort_en_async_low", lcd_en, 1'b0);
        check("abort_data_low", lcd_data, 8'h00);
        check("abort_rs_low", lcd_rs, 1'b0);
        check("abort_ready", char_ready, 1'b1);
        check("abort_busy", busy, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
        txq.delete();
        wait_idle("abort_reinit_idle", at);
        check("abort_reinit_idle_cyc", at, 57);
        check("abort_fifo_flushed_tx_count", txq.size(), 4);
        check_init("abort");
        check("abort_row", cursor_row, 1'b0);
        check("abort_col", cursor_col, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_text_engine.md
# lcd_text_engine

- Parametrised HD44780-compatible character-LCD controller.
- Buffers incoming characters in an internal FIFO, runs the power-on init sequence, tracks the cursor, and auto-wraps across a configurable ROWS×COLS geometry.
- Sits between the print-pattern source and the LCD pins, replacing the fixed single-character driver. It adds buffering, geometry awareness, clear/newline handling and parametrised bus timing.

## Interface
- CLK_HZ, 50_000_000: clock frequency; documentation only, all timing is given in cycles below.
- ROWS, 2: display rows; legal values 1, 2, 4.
- COLS, 16: display columns, 8..40.
- FIFO_DEPTH, 16: character FIFO entries; must be a power of 2, ≥2.
- T_PWR_CYC, 750_000: power-on wait before the first command (15 ms at 50 MHz).
- T_EN_CYC, 25: lcd_en high width in cycles.
- T_CMD_CYC, 2_000: post-transaction wait for normal commands and data (40 µs).
- T_CLR_CYC, 82_000: post-transaction wait after clear 0x01 (1.64 ms).
- clk  in  1  system clock.
- rstb  in  1  asynchronous, active-low reset.
- char_in  in  8  character or control code.
- char_valid  in  1  char_in valid.
- char_ready  out  1  FIFO not full; a push occurs on char_valid && char_ready.
- busy  out  1  high while initialising, while a transaction is in flight, or while the FIFO is non-empty.
- cursor_row  out  $clog2(ROWS) (min 1)  row of the next character.
- cursor_col  out  $clog2(COLS)  column of the next character.
- lcd_data  out  8  LCD data bus (8-bit mode).
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_rw  out  1  tied 0 (write-only).
- lcd_en  out  1  LCD enable strobe.

## Operation
- Reset values:
  - All LCD outputs 0.
  - char_ready 1, busy 1.
  - cursor 0,0; FIFO empty.
  - FSM in PWR_WAIT.
  - Reset mid-transaction aborts immediately: lcd_en drops to 0 asynchronously and the FIFO contents are discarded.
- FSM states: PWR_WAIT → INIT → IDLE ↔ XFER → WAIT.
- PWR_WAIT: counts T_PWR_CYC cycles.
- INIT: issues four commands in order, each a full transaction:
  - 0x38 function set (0x30 if ROWS==1).
  - 0x0C display on, cursor off.
  - 0x01 clear (uses T_CLR_CYC).
  - 0x06 entry mode, increment.
- IDLE: if the FIFO is non-empty, pop the head (pop in the same cycle XFER is entered) and decode it:
  - Printable byte: data write (rs=1).
  - Pending wrap: if the cursor was moved by a wrap or newline, a set-DDRAM command 0x80|addr(row,0) is issued first, then the data write.
- Cursor update: after each data write, col increments. When col == COLS-1, col→0 and row→(row+1) mod ROWS, and the pending-address flag is set.
- DDRAM address per row:
  - row 0 = 0x00.
  - row 1 = 0x40.
  - row 2 = COLS.
  - row 3 = 0x40+COLS.
- Wrap past the last row returns to row 0. Existing text is overwritten; there is no scrolling.
- FIFO:
  - Accepts pushes in every state, including PWR_WAIT/INIT.
  - char_ready = !full.
  - A push and pop in the same cycle are both honoured; the count is unchanged.
  - A full FIFO deasserts char_ready the cycle after the last push fills it.

## Timing
- One transaction:
  - 1 setup cycle: rs/data valid, en=0.
  - T_EN_CYC cycles en=1.
  - T_CMD_CYC (or T_CLR_CYC) cycles en=0 with rs/data held.
- rs/data change only in the setup cycle.
- Transactions are back-to-back. The next setup cycle follows the last wait cycle directly, except that one IDLE cycle is inserted before each FIFO pop.
- First lcd_en rising edge occurs T_PWR_CYC+1 cycles after rstb deasserts.
- busy falls in the cycle the FSM enters IDLE with the FIFO empty.
- cursor_row/cursor_col update on the cycle the data transaction's wait completes.

## Configuration
- LCD_CTRL_CHARS_EN defined: control codes are interpreted.
  - 0x0A newline: row→(row+1) mod ROWS, col→0, then the set-DDRAM command is issued immediately.
  - 0x0C form-feed: issue 0x01 with T_CLR_CYC wait, cursor→0,0.
  - Neither code produces a data write.
- LCD_CTRL_CHARS_EN undefined: all bytes, including 0x0A and 0x0C, are written as data with rs=1.

## Test plan
All scenarios use ROWS=2, COLS=4, FIFO_DEPTH=4, T_PWR_CYC=20, T_EN_CYC=2, T_CMD_CYC=5, T_CLR_CYC=10.
- Reset release:
  - lcd_en stays 0 for 21 cycles.
  - Then the command sequence 0x38, 0x0C, 0x01, 0x06 appears with rs=0.
  - The third command is followed by a 10-cycle wait; busy falls after the last wait.
- Push "ABCDE" after init: data bytes 0x41..0x44 are written (rs=1), then command 0xC0, then data 0x45; cursor ends at 1,1.
- Push 9 characters filling a full 2×4 display: after the 8th, command 0x80 is issued and the 9th character lands at 0,0.
- With LCD_CTRL_CHARS_EN: push 'A', 0x0A, 'B' → 0x41, cmd 0xC0, 0x42. Then push 0x0C → cmd 0x01 with a 10-cycle wait; cursor 0,0.
- Push 6 characters during PWR_WAIT:
  - char_ready drops after the 4th push.
  - The 5th push is held until the first pop.
  - All 6 characters appear, in order, after init.
- Assert rstb low while lcd_en=1: lcd_en→0 asynchronously, the FIFO is emptied, and the full init sequence repeats after release.
